fb_mem_arbiter: RTL
===================

FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

Interface
REQ-001 Parameters SHALL be: FB_W, default 160, framebuffer width in words; FB_H, default 120, framebuffer height in words; SCALE_LOG2, default 2, display-pixel to framebuffer-word upscale shift.
REQ-002 clk_pix  in  1  pixel clock; sole clock.
REQ-003 rst_pix_n  in  1  reset; asynchronous assert, active-low.
REQ-004 sx, sy  in  11 signed each  timing-generator position.
REQ-005 de, frame  in  1 each  data enable; start-of-frame strobe.
REQ-006 o_sx, o_sy  out  11 signed each  position delayed by LATENCY.
REQ-007 o_de, o_frame  out  1 each  de and frame delayed by LATENCY.
REQ-008 o_rgb  out  12  pixel colour: [11:8] blue, [7:4] green, [3:0] red.
REQ-009 wr_req[1:0], wr_ack[1:0]  in/out  2 each  per-writer request; per-writer accept.
REQ-010 wr_addr0/1  in  15 each  word address. wr_data0/1  in  12 each  word data.
REQ-011 clr_start  in  1  clear request pulse. clr_color  in  12  fill value. clr_busy  out  1  clear in progress.
REQ-012 addr_err  out  1  sticky flag: an out-of-range write was accepted.
REQ-013 mem_en, mem_we  out  1 each; mem_addr  out  15; mem_wdata  out  12; mem_rdata  in  12  single-port RAM with 1-cycle read latency.

Function
REQ-014 Slots: a cycle with de=1 and sx[1:0]=0 SHALL be a scanout slot; every other cycle SHALL be a free slot.
REQ-015 Scanout slot: the block SHALL issue a read with mem_addr = (sy>>2)*FB_W + (sx>>2), computed with shifts and adds, no multiplier.
REQ-016 Each returned word SHALL be held in a pixel register and driven on o_rgb for 4 consecutive output cycles.
REQ-017 The position-to-pixel latency SHALL be LATENCY=3 cycles: mem_* registered (+1), RAM read (+1), pixel register (+1).
REQ-018 o_rgb SHALL be 0 whenever o_de=0.
REQ-019 Free-slot priority SHALL be: clear engine first, then writers.
REQ-020 Writer grant SHALL be round-robin: when both request, grant the writer not granted last; reset pointer favours writer 0.
REQ-021 wr_ack[i] SHALL be combinational and asserted only in a free slot where writer i is granted.
REQ-022 The writer SHALL hold req/addr/data until ack; the accepted write SHALL appear on the registered mem_* outputs the next cycle.
REQ-023 At most one wr_ack bit SHALL be high per cycle, and none during a scanout slot or while clr_busy=1.
REQ-024 Accepted write with addr >= FB_W*FB_H: it SHALL be acked, no RAM write SHALL be issued, and addr_err SHALL set (cleared only by reset).
REQ-025 Clear FSM states SHALL be IDLE and CLEAR.
REQ-026 IDLE->CLEAR on clr_start: clr_busy=1, clear address=0, colour latched from clr_color.
REQ-027 In CLEAR, each free slot SHALL write the latched colour to the clear address and increment it.
REQ-028 CLEAR->IDLE after address FB_W*FB_H-1 is written; clr_busy SHALL drop the cycle after that write.
REQ-029 clr_start while in CLEAR SHALL be ignored.
REQ-030 mem_en=0 and mem_we=0 SHALL hold in cycles with no access; mem_addr and mem_wdata are don't-care then.

Reset
REQ-031 While rst_pix_n=0: all outputs SHALL be 0, the FSM SHALL be IDLE, the round-robin pointer SHALL be 0, and the pixel register SHALL be 0.
REQ-032 Reset mid-clear SHALL abandon the clear; memory contents are unspecified.
REQ-033 Outputs SHALL become valid LATENCY cycles after reset release.

Structure
REQ-034 Package fb_pkg SHALL hold: FB_W, FB_H, FB_WORDS, ADDR_W=15, RGB_W=12, LATENCY=3 and the clear-FSM state typedef.
REQ-035 The 2-way round-robin SHALL be sub-module fb_rr_arb2 (req[1:0], enable -> grant[1:0], registered pointer).

Verification
REQ-036 RAM preloaded word k = k[11:0]; full frame -> o_rgb at o_sx=8, o_sy=4 equals 12'd162, each word held 4 pixels, aligned at latency 3.
REQ-037 Writer 0 held at addr 5, data 12'hABC, from sx=0 with de=1 -> ack at sx=1, never at sx=0 or 4; RAM[5]=12'hABC.
REQ-038 Both writers requesting continuously during blanking -> acks alternate 0,1,0,1; never both high.
REQ-039 clr_start, clr_color=12'h0F0, writer 1 requesting -> no wr_ack until clr_busy falls; all 19200 words = 12'h0F0; second clr_start mid-clear ignored.
REQ-040 Writer 0 at addr 19200 -> acked, no mem_we, addr_err=1 persists until reset.
REQ-041 rst_pix_n pulsed low mid-clear -> all outputs 0 immediately (asynchronously), FSM IDLE, clr_busy=0 after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the framebuffer memory arbiter.
// Everything here is elaboration-time only; no logic is instantiated.
package fb_pkg;

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_WORDS = FB_W * FB_H;
   localparam int ADDR_W   = 15;
   localparam int RGB_W    = 12;
   localparam int LATENCY  = 3;
   localparam int POS_W    = 11;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   typedef struct packed {
      logic signed [POS_W-1:0] sx;
      logic signed [POS_W-1:0] sy;
      logic                    de;
      logic                    frame;
   } pos_t;

   // Multiply by a constant as a sum of shifted copies, so no multiplier is built.
   function automatic logic [ADDR_W-1:0] mul_const(input logic [ADDR_W-1:0] a, input int k);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (k[i]) acc = acc + (a << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter. When both requesters are active, the one
// that was not granted most recently wins; after reset writer 0 is favoured.
module fb_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic ptr_reg;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) grant = ptr_reg ? 2'b10 : 2'b01;
         else              grant = req;
      end
   end

   // The pointer names the writer preferred on the next contended cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr_reg <= 1'b0;
      else if (grant[0]) ptr_reg <= 1'b1;
      else if (grant[1]) ptr_reg <= 1'b0;
   end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: scanout reads on every upscaled pixel group,
// with the remaining slots shared by a fill engine and two round-robin writers.
module fb_mem_arbiter #(
   parameter int FB_W       = fb_pkg::FB_W,
   parameter int FB_H       = fb_pkg::FB_H,
   parameter int SCALE_LOG2 = 2
) (
   input  logic                              clk_pix,
   input  logic                              rst_pix_n,
   input  logic signed [fb_pkg::POS_W-1:0]   sx,
   input  logic signed [fb_pkg::POS_W-1:0]   sy,
   input  logic                              de,
   input  logic                              frame,
   output logic signed [fb_pkg::POS_W-1:0]   o_sx,
   output logic signed [fb_pkg::POS_W-1:0]   o_sy,
   output logic                              o_de,
   output logic                              o_frame,
   output logic [fb_pkg::RGB_W-1:0]          o_rgb,
   input  logic [1:0]                        wr_req,
   output logic [1:0]                        wr_ack,
   input  logic [fb_pkg::ADDR_W-1:0]         wr_addr0,
   input  logic [fb_pkg::ADDR_W-1:0]         wr_addr1,
   input  logic [fb_pkg::RGB_W-1:0]          wr_data0,
   input  logic [fb_pkg::RGB_W-1:0]          wr_data1,
   input  logic                              clr_start,
   input  logic [fb_pkg::RGB_W-1:0]          clr_color,
   output logic                              clr_busy,
   output logic                              addr_err,
   output logic                              mem_en,
   output logic                              mem_we,
   output logic [fb_pkg::ADDR_W-1:0]         mem_addr,
   output logic [fb_pkg::RGB_W-1:0]          mem_wdata,
   input  logic [fb_pkg::RGB_W-1:0]          mem_rdata
);

   import fb_pkg::*;

   localparam int WORDS    = FB_W * FB_H;
   localparam int SUB_MASK = (1 << SCALE_LOG2) - 1;

   logic [POS_W-1:0]  sx_u, sy_u;
   logic              scan_slot, free_slot;
   logic [ADDR_W-1:0] row, col, scan_addr;

   assign sx_u      = sx;
   assign sy_u      = sy;
   assign scan_slot = de && ((sx_u & POS_W'(SUB_MASK)) == '0);
   assign free_slot = !scan_slot;
   assign row       = ADDR_W'(sy_u >> SCALE_LOG2);
   assign col       = ADDR_W'(sx_u >> SCALE_LOG2);
   assign scan_addr = mul_const(row, FB_W) + col;

   // ---------------- clear engine ----------------
   clr_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
   logic [RGB_W-1:0]  clr_color_reg, clr_color_next;
   logic              clr_write;

   assign clr_busy  = (state_reg == CLEAR);
   assign clr_write = clr_busy && free_slot;

   always_comb begin
      state_next     = state_reg;
      clr_addr_next  = clr_addr_reg;
      clr_color_next = clr_color_reg;
      case (state_reg)
         IDLE: begin
            if (clr_start) begin
               state_next     = CLEAR;
               clr_addr_next  = '0;
               clr_color_next = clr_color;
            end
         end
         CLEAR: begin
            if (free_slot) begin
               clr_addr_next = clr_addr_reg + 1'b1;
               if (clr_addr_reg == ADDR_W'(WORDS - 1)) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state_reg     <= IDLE;
         clr_addr_reg  <= '0;
         clr_color_reg <= '0;
      end else begin
         state_reg     <= state_next;
         clr_addr_reg  <= clr_addr_next;
         clr_color_reg <= clr_color_next;
      end
   end

   // ---------------- writers ----------------
   logic [1:0]        grant;
   logic              wr_any, wr_in_range;
   logic [ADDR_W-1:0] wr_sel_addr;
   logic [RGB_W-1:0]  wr_sel_data;

   fb_rr_arb2 u_arb (
      .clk    (clk_pix),
      .rst_n  (rst_pix_n),
      .req    (wr_req),
      .enable (free_slot && !clr_busy),
      .grant  (grant)
   );

   // Ack is combinational, so it must be masked explicitly while reset is held.
   assign wr_ack      = grant & {2{rst_pix_n}};
   assign wr_any      = |grant;
   assign wr_sel_addr = grant[1] ? wr_addr1 : wr_addr0;
   assign wr_sel_data = grant[1] ? wr_data1 : wr_data0;
   assign wr_in_range = wr_sel_addr < ADDR_W'(WORDS);

   // ---------------- memory port ----------------
   logic              mem_en_next, mem_we_next;
   logic [ADDR_W-1:0] mem_addr_next;
   logic [RGB_W-1:0]  mem_wdata_next;

   always_comb begin
      mem_en_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_addr_next  = '0;
      mem_wdata_next = '0;
      if (scan_slot) begin
         mem_en_next   = 1'b1;
         mem_addr_next = scan_addr;
      end else if (clr_write) begin
         mem_en_next    = 1'b1;
         mem_we_next    = 1'b1;
         mem_addr_next  = clr_addr_reg;
         mem_wdata_next = clr_color_reg;
      end else if (wr_any && wr_in_range) begin
         mem_en_next    = 1'b1;
         mem_we_next    = 1'b1;
         mem_addr_next  = wr_sel_addr;
         mem_wdata_next = wr_sel_data;
      end
   end

   logic             rd_q1_reg, rd_q2_reg;
   logic [RGB_W-1:0] pixel_reg;
   logic             addr_err_reg;

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         rd_q1_reg    <= 1'b0;
         rd_q2_reg    <= 1'b0;
         pixel_reg    <= '0;
         addr_err_reg <= 1'b0;
      end else begin
         mem_en    <= mem_en_next;
         mem_we    <= mem_we_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         rd_q1_reg <= scan_slot;
         rd_q2_reg <= rd_q1_reg;
         // rd_q2 marks the cycle in which the RAM presents the scanout word.
         if (rd_q2_reg) pixel_reg <= mem_rdata;
         if (wr_any && !wr_in_range) addr_err_reg <= 1'b1;
      end
   end

   assign addr_err = addr_err_reg;

   // ---------------- timing delay line ----------------
   pos_t pos_pipe [LATENCY];

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         for (int i = 0; i < LATENCY; i++) pos_pipe[i] <= '0;
      end else begin
         pos_pipe[0] <= '{sx: sx, sy: sy, de: de, frame: frame};
         for (int i = 1; i < LATENCY; i++) pos_pipe[i] <= pos_pipe[i-1];
      end
   end

   assign o_sx    = pos_pipe[LATENCY-1].sx;
   assign o_sy    = pos_pipe[LATENCY-1].sy;
   assign o_de    = pos_pipe[LATENCY-1].de;
   assign o_frame = pos_pipe[LATENCY-1].frame;
   assign o_rgb   = o_de ? pixel_reg : '0;

endmodule
